// File: rtl/mp3_feed_pkg.sv
// Shared types for the MP3 bitstream feed controller.
// Optional frame limit: define MP3_FEED_FRAME_LIMIT_EN.
package mp3_feed_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE,
        ERR
    } state_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mp3_feed_buf.sv
// Show-ahead prefetch FIFO feeding the decoder.
// Optional frame limit in top: MP3_FEED_FRAME_LIMIT_EN.
module mp3_feed_buf
    import mp3_feed_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W = 32,
    localparam int CNTW = cnt_w(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr,
    input  logic [W-1:0]    wdata,
    input  logic            pop,
    input  logic            flush,
    output logic [W-1:0]    head,
    output logic            empty,
    output logic [CNTW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]    mem [DEPTH];
    logic [PW-1:0]   wp;
    logic [PW-1:0]   rp;
    logic [CNTW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            cnt <= cnt + CNTW'(wr) - CNTW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (wr)
            mem[wp] <= wdata;
    end

    // Head reads as zero when empty so stale entries never leak out.
    assign empty = (cnt == '0);
    assign head  = empty ? '0 : mem[rp];
    assign count = cnt;

endmodule

// File: rtl/mp3_feed_ctrl.sv
// Memory-to-Mp3Decode bitstream feed controller with frame counting.
// Optional frame limit (max_frames port): MP3_FEED_FRAME_LIMIT_EN.
module mp3_feed_ctrl
    import mp3_feed_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW = 20,
    parameter int CW = 16
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   word_count,
`ifdef MP3_FEED_FRAME_LIMIT_EN
    input  logic [CW-1:0] max_frames,
`endif
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_rvalid,
    input  logic [31:0]   mem_rdata,
    output logic          Enable,
    output logic          fifo_empty,
    output logic [31:0]   fifo_datain,
    input  logic          fifo_ren,
    input  logic          Invalid_format,
    input  logic          frame_done,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [CW-1:0] frame_cnt,
    output logic [AW:0]   words_sent
);

    localparam int CNTW = cnt_w(DEPTH);

    state_t          state;
    logic [AW:0]     count_q;
    logic [AW:0]     issued;
    logic [AW:0]     issued_n;
    logic [CNTW-1:0] outstanding;
    logic [CNTW-1:0] out_n;
    logic [CNTW-1:0] occ;
    logic [CNTW-1:0] occ_n;
    logic            toggle;
    logic            stop;
    logic            active;
    logic            rv;
    logic            wr;
    logic            pop;
    logic            abort;
    logic            limit_hit;
    logic            flush;
    logic            credit_ok;
    logic            buf_empty;
    logic [31:0]     head;
`ifdef MP3_FEED_FRAME_LIMIT_EN
    logic [CW-1:0]   max_q;
`endif

    always_comb begin
        active = (state == RUN) || (state == DRAIN);
        abort  = active && Invalid_format;
`ifdef MP3_FEED_FRAME_LIMIT_EN
        limit_hit = active && !stop && (max_q != '0)
                    && (frame_cnt >= max_q);
`else
        limit_hit = 1'b0;
`endif
        flush = abort || limit_hit;
        // Reads only count while something is really in flight.
        rv = mem_rvalid && (outstanding != '0)
             && (active || state == ERR);
        wr = rv && active && !stop && !flush;
        pop = fifo_ren && !buf_empty && active;
        issued_n = issued + (AW+1)'(mem_req);
        out_n = outstanding + CNTW'(mem_req) - CNTW'(rv);
        occ_n = occ + CNTW'(wr) - CNTW'(pop);
        credit_ok = ({1'b0, occ_n} + {1'b0, out_n})
                    < (CNTW+1)'(DEPTH);
    end

    mp3_feed_buf #(
        .DEPTH(DEPTH),
        .W    (32)
    ) u_buf (
        .clk  (Clk),
        .rst  (Rst),
        .wr   (wr),
        .wdata(mem_rdata),
        .pop  (pop),
        .flush(flush),
        .head (head),
        .empty(buf_empty),
        .count(occ)
    );

    assign fifo_empty  = buf_empty;
    assign fifo_datain = head;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            Enable      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            frame_cnt   <= '0;
            words_sent  <= '0;
            count_q     <= '0;
            issued      <= '0;
            outstanding <= '0;
            toggle      <= 1'b0;
            stop        <= 1'b0;
`ifdef MP3_FEED_FRAME_LIMIT_EN
            max_q       <= '0;
`endif
        end else begin
            outstanding <= out_n;
            issued      <= issued_n;
            if (pop)
                words_sent <= words_sent + 1'b1;
            if (mem_req)
                mem_addr <= mem_addr + 1'b1;
            if (frame_done) begin
                toggle <= ~toggle;
                if (toggle && frame_cnt != '1)
                    frame_cnt <= frame_cnt + 1'b1;
            end
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        count_q    <= word_count;
                        issued     <= '0;
                        words_sent <= '0;
                        frame_cnt  <= '0;
                        toggle     <= 1'b0;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        stop       <= 1'b0;
                        mem_addr   <= base_addr;
                        Enable     <= 1'b1;
`ifdef MP3_FEED_FRAME_LIMIT_EN
                        max_q      <= max_frames;
`endif
                        if (word_count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= RUN;
                            busy    <= 1'b1;
                            mem_req <= 1'b1;
                        end
                    end
                end
                RUN, DRAIN: begin
                    if (abort) begin
                        state   <= ERR;
                        Enable  <= 1'b0;
                        mem_req <= 1'b0;
                        error   <= 1'b1;
                    end else if (limit_hit) begin
                        state   <= DRAIN;
                        stop    <= 1'b1;
                        mem_req <= 1'b0;
                    end else if (state == RUN) begin
                        if (issued_n == count_q) begin
                            state   <= DRAIN;
                            mem_req <= 1'b0;
                        end else begin
                            mem_req <= credit_ok;
                        end
                    end else if (outstanding == '0 && buf_empty) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                ERR: begin
                    if (outstanding == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mp3_feed_ctrl.sv
// Randomized self-checking bench for mp3_feed_ctrl.
// Exercises the frame limit when MP3_FEED_FRAME_LIMIT_EN is defined.
module tb_mp3_feed_ctrl;

    localparam int DEPTH = 4;
    localparam int AW = 20;
    localparam int CW = 3;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   word_count = '0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_rvalid = 1'b0;
    logic [31:0]   mem_rdata = '0;
    logic          Enable;
    logic          fifo_empty;
    logic [31:0]   fifo_datain;
    logic          fifo_ren = 1'b0;
    logic          Invalid_format = 1'b0;
    logic          frame_done = 1'b0;
    logic          busy;
    logic          done;
    logic          error;
    logic [CW-1:0] frame_cnt;
    logic [AW:0]   words_sent;
`ifdef MP3_FEED_FRAME_LIMIT_EN
    logic [CW-1:0] max_frames = '0;
`endif

    mp3_feed_ctrl #(
        .DEPTH(DEPTH),
        .AW   (AW),
        .CW   (CW)
    ) dut (
`ifdef MP3_FEED_FRAME_LIMIT_EN
        .max_frames    (max_frames),
`endif
        .Clk           (Clk),
        .Rst           (Rst),
        .start         (start),
        .base_addr     (base_addr),
        .word_count    (word_count),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .Enable        (Enable),
        .fifo_empty    (fifo_empty),
        .fifo_datain   (fifo_datain),
        .fifo_ren      (fifo_ren),
        .Invalid_format(Invalid_format),
        .frame_done    (frame_done),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .frame_cnt     (frame_cnt),
        .words_sent    (words_sent)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [AW-1:0] a;
        int            due;
    } rq_t;

    rq_t           q[$];
    logic [AW-1:0] addr_log[$];
    logic [31:0]   memd[int];
    int            vecs = 0;
    int            fails = 0;
    int            cyc = 0;
    int            req_n = 0;
    int            pop_n = 0;
    int            resp_n = 0;
    int            exp_cnt = 0;
    int            lat_lo = 1;
    int            lat_hi = 1;
    int            ren_mode = 0;
    int            last_due = 0;
    logic [AW-1:0] exp_base = '0;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One cycle: memory model, decoder model, then the clock edge.
    task automatic tick();
        logic [AW-1:0] ea;
        int            k;
        int            d;
        if (mem_req === 1'b1) begin
            ea = exp_base + AW'(req_n);
            check("addr", mem_addr, ea);
            check("overissue", req_n < exp_cnt, 1);
            check("credit", (req_n + 1 - pop_n) <= DEPTH, 1);
            k = int'(mem_addr);
            if (!memd.exists(k))
                memd[k] = $urandom;
            d = cyc + int'($urandom_range(lat_hi, lat_lo));
            if (d <= last_due)
                d = last_due + 1;
            last_due = d;
            q.push_back('{a: mem_addr, due: d});
            addr_log.push_back(mem_addr);
            req_n++;
        end
        if (q.size() > 0 && q[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = memd[int'(q[0].a)];
            void'(q.pop_front());
            resp_n++;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
        case (ren_mode)
            0: fifo_ren = 1'b0;
            1: fifo_ren = 1'b1;
            default: fifo_ren = 1'($urandom_range(1, 0));
        endcase
        if (fifo_ren && fifo_empty === 1'b0) begin
            ea = exp_base + AW'(pop_n);
            check("data", fifo_datain, memd[int'(ea)]);
            pop_n++;
        end
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic start_stream(input logic [AW-1:0] b,
                                input int n);
        exp_base = b;
        exp_cnt = n;
        req_n = 0;
        pop_n = 0;
        resp_n = 0;
        addr_log.delete();
        base_addr = b;
        word_count = (AW+1)'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        for (int i = 0; i < budget && !(done || error); i++)
            tick();
    endtask

    task automatic check_reset();
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_en", Enable, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_data", fifo_datain, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", error, 0);
        check("rst_fcnt", frame_cnt, 0);
        check("rst_sent", words_sent, 0);
    endtask

    task automatic check_ok(input string tag, input int n);
        check({tag, "_done"}, done, 1);
        check({tag, "_err"}, error, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_sent"}, words_sent, n);
        check({tag, "_pops"}, pop_n, n);
        check({tag, "_reqs"}, req_n, n);
        check({tag, "_empty"}, fifo_empty, 1);
        check({tag, "_en"}, Enable, 1);
    endtask

    initial begin
        int n;
        tick();
        tick();
        check_reset();
        Rst = 1'b0;
        tick();

        // Basic stream, fixed latency 3, pop every cycle.
        lat_lo = 3;
        lat_hi = 3;
        ren_mode = 1;
        start_stream(20'h00100, 10);
        check("basic_busy", busy, 1);
        check("basic_en", Enable, 1);
        wait_end(300);
        check_ok("basic", 10);

        // Invalid_format outside a stream has no effect.
        Invalid_format = 1'b1;
        tick();
        Invalid_format = 1'b0;
        check("idle_fmt_err", error, 0);
        check("idle_fmt_done", done, 1);

        // Random streams, random latency and decoder pacing.
        for (int r = 0; r < 4; r++) begin
            lat_lo = 1;
            lat_hi = int'($urandom_range(5, 1));
            ren_mode = 2;
            n = int'($urandom_range(20, 1));
            start_stream(AW'($urandom), n);
            wait_end(600);
            check_ok("rand", n);
        end

        // Backpressure plus frame counting while stalled.
        lat_lo = 2;
        lat_hi = 2;
        ren_mode = 0;
        start_stream(20'h00200, 10);
        for (int i = 0; i < 20; i++)
            tick();
        check("bp_reqs", req_n, DEPTH);
        check("bp_req", mem_req, 0);
        check("bp_head", fifo_empty, 0);
        for (int k = 1; k <= 16; k++) begin
            frame_done = 1'b1;
            tick();
            frame_done = 1'b0;
            check("frame_cnt", frame_cnt,
                  (k / 2 > 7) ? 7 : k / 2);
            tick();
        end
        check("bp_reqs2", req_n, DEPTH);
        ren_mode = 1;
        wait_end(300);
        check_ok("bp", 10);

        // Abort on Invalid_format after five pops.
        lat_lo = 3;
        lat_hi = 3;
        start_stream(20'h00300, 10);
        for (int i = 0; i < 100 && pop_n < 5; i++)
            tick();
        ren_mode = 0;
        Invalid_format = 1'b1;
        tick();
        Invalid_format = 1'b0;
        check("err_en", Enable, 0);
        check("err_req", mem_req, 0);
        check("err_flag", error, 1);
        check("err_busy1", busy, 1);
        for (int i = 0; i < 50 && busy; i++) begin
            check("err_empty_d", fifo_empty, 1);
            check("err_req_d", mem_req, 0);
            tick();
        end
        check("err_busy0", busy, 0);
        check("err_flag2", error, 1);
        check("err_empty", fifo_empty, 1);
        check("err_drained", q.size(), 0);
        check("err_sent", words_sent, 5);
        check("err_done", done, 0);

`ifdef MP3_FEED_FRAME_LIMIT_EN
        max_frames = 3'd2;
        ren_mode = 0;
        start_stream(20'h00400, 20);
        for (int k = 1; k <= 3; k++) begin
            frame_done = 1'b1;
            tick();
            frame_done = 1'b0;
            tick();
        end
        check("lim_busy", busy, 1);
        check("lim_done0", done, 0);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        wait_end(100);
        check("lim_done", done, 1);
        check("lim_err", error, 0);
        check("lim_fcnt", frame_cnt, 2);
        check("lim_busy0", busy, 0);
        for (int i = 0; i < 8; i++) begin
            check("lim_noreq", mem_req, 0);
            tick();
        end
        max_frames = '0;
`endif

        // Address wrap at the top of the space.
        lat_lo = 2;
        lat_hi = 2;
        ren_mode = 1;
        start_stream(20'hFFFFE, 4);
        wait_end(200);
        check_ok("wrap", 4);
        check("wrap_n", addr_log.size(), 4);
        if (addr_log.size() == 4) begin
            check("wrap_a0", addr_log[0], 20'hFFFFE);
            check("wrap_a1", addr_log[1], 20'hFFFFF);
            check("wrap_a2", addr_log[2], 20'h00000);
            check("wrap_a3", addr_log[3], 20'h00001);
        end

        // Reset while the buffer holds words.
        lat_lo = 1;
        lat_hi = 1;
        ren_mode = 0;
        start_stream(20'h00500, 10);
        for (int i = 0; i < 50 && resp_n < 3; i++)
            tick();
        tick();
        check("mid_held", fifo_empty, 0);
        Rst = 1'b1;
        tick();
        check_reset();
        Rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("post_empty", fifo_empty, 1);
            tick();
        end
        check("post_busy", busy, 0);

        start_stream(20'h00600, 0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_en", Enable, 1);
        for (int i = 0; i < 6; i++) begin
            check("zero_noreq", mem_req, 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, fails);
        $finish;
    end

endmodule
